// File: rtl/bin2gray_stream.sv
// Streaming binary-to-Gray encoder with a two-entry skid buffer.
// Ports: clk/rst, in_valid/in_ready/in_bin, out_valid/out_ready,
//   out_gray/out_bin/out_step, xfer_cnt (output transfers, wraps).
module bin2gray_stream #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gray,
  output logic [WIDTH-1:0] out_bin,
  output logic             out_step,
  output logic [CNT_W-1:0] xfer_cnt
);

  logic             out_v_q, out_v_d;
  logic [WIDTH-1:0] out_gray_q, out_gray_d;
  logic [WIDTH-1:0] out_bin_q, out_bin_d;
  logic             out_step_q, out_step_d;
  logic             skid_v_q, skid_v_d;
  logic [WIDTH-1:0] skid_gray_q, skid_gray_d;
  logic [WIDTH-1:0] skid_bin_q, skid_bin_d;
  logic             skid_step_q, skid_step_d;
  logic [WIDTH-1:0] last_gray_q, last_gray_d;
  logic             last_v_q, last_v_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             in_xfer;
  logic             out_xfer;
  logic [WIDTH-1:0] gray_in;
  logic [WIDTH-1:0] diff;
  logic             step_in;

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = out_v_q && out_ready;
  assign gray_in  = in_bin ^ (in_bin >> 1);
  assign diff     = gray_in ^ last_gray_q;
  // Exactly one differing bit against the previously accepted word.
  assign step_in  = last_v_q && $onehot(diff);

  always_comb begin
    out_v_d     = out_v_q;
    out_gray_d  = out_gray_q;
    out_bin_d   = out_bin_q;
    out_step_d  = out_step_q;
    skid_v_d    = skid_v_q;
    skid_gray_d = skid_gray_q;
    skid_bin_d  = skid_bin_q;
    skid_step_d = skid_step_q;
    last_gray_d = last_gray_q;
    last_v_d    = last_v_q;
    cnt_d       = cnt_q + CNT_W'(out_xfer);
    if (!out_v_q || out_xfer) begin
      // OUT is free this edge: refill from SKID first, then input.
      if (skid_v_q) begin
        out_v_d    = 1'b1;
        out_gray_d = skid_gray_q;
        out_bin_d  = skid_bin_q;
        out_step_d = skid_step_q;
        skid_v_d   = 1'b0;
      end else if (in_xfer) begin
        out_v_d    = 1'b1;
        out_gray_d = gray_in;
        out_bin_d  = in_bin;
        out_step_d = step_in;
      end else begin
        out_v_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_v_d    = 1'b1;
      skid_gray_d = gray_in;
      skid_bin_d  = in_bin;
      skid_step_d = step_in;
    end
    if (in_xfer) begin
      last_gray_d = gray_in;
      last_v_d    = 1'b1;
    end
    in_ready_d = !(out_v_d && skid_v_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_v_q     <= 1'b0;
      out_gray_q  <= '0;
      out_bin_q   <= '0;
      out_step_q  <= 1'b0;
      skid_v_q    <= 1'b0;
      skid_gray_q <= '0;
      skid_bin_q  <= '0;
      skid_step_q <= 1'b0;
      last_gray_q <= '0;
      last_v_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_v_q     <= out_v_d;
      out_gray_q  <= out_gray_d;
      out_bin_q   <= out_bin_d;
      out_step_q  <= out_step_d;
      skid_v_q    <= skid_v_d;
      skid_gray_q <= skid_gray_d;
      skid_bin_q  <= skid_bin_d;
      skid_step_q <= skid_step_d;
      last_gray_q <= last_gray_d;
      last_v_q    <= last_v_d;
      in_ready_q  <= in_ready_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_v_q;
  assign out_gray  = out_gray_q;
  assign out_bin   = out_bin_q;
  assign out_step  = out_step_q;
  assign xfer_cnt  = cnt_q;

endmodule
